// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache for the IF stage.
// Combinational hit path; a miss stalls the pipeline and refills one
// full line, one word per mem_rvalid beat, from the backing memory.
module inst_cache #(
  parameter int LINE_ADDR_LEN = 2,
  parameter int SET_ADDR_LEN  = 4,
  parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [31:0] addr,
  input  logic        invalidate,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int WORDS   = 1 << LINE_ADDR_LEN;
  localparam int SETS    = 1 << SET_ADDR_LEN;
  localparam int IDX_LSB = LINE_ADDR_LEN + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [31:0]             data_q [SETS][WORDS];
  logic [TAG_ADDR_LEN-1:0] tag_q  [SETS];
  logic [SETS-1:0]         valid_q, valid_d;

  logic [1:0]               state_q, state_d;
  logic [LINE_ADDR_LEN-1:0] cnt_q, cnt_d;
  logic                     mem_req_q, mem_req_d;
  logic [31:0]              mem_addr_q, mem_addr_d;
  logic [31:0]              hit_cnt_q, hit_cnt_d;
  logic [31:0]              miss_cnt_q, miss_cnt_d;
  logic                     inv_pend_q, inv_pend_d;

  // Fetch address fields
  logic [LINE_ADDR_LEN-1:0] off;
  logic [SET_ADDR_LEN-1:0]  idx;
  logic [TAG_ADDR_LEN-1:0]  tag;
  assign off = addr[2 +: LINE_ADDR_LEN];
  assign idx = addr[IDX_LSB +: SET_ADDR_LEN];
  assign tag = addr[31 -: TAG_ADDR_LEN];

  // Refill target comes from the latched line address, never from addr
  logic [SET_ADDR_LEN-1:0] ref_idx;
  logic [TAG_ADDR_LEN-1:0] ref_tag;
  assign ref_idx = mem_addr_q[IDX_LSB +: SET_ADDR_LEN];
  assign ref_tag = mem_addr_q[31 -: TAG_ADDR_LEN];

  logic addr_unused;
  assign addr_unused = ^addr[1:0];

  logic hit, last_beat;
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign last_beat = (cnt_q == LINE_ADDR_LEN'(WORDS - 1));

  assign rd_data  = (state_q == S_IDLE) ? data_q[idx][off] : 32'd0;
  assign miss     = (state_q != S_IDLE) || (rd_req && !hit);
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Control FSM next state: lookup, refill sequencing, invalidate, stats
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    inv_pend_d = inv_pend_q;
    valid_d    = valid_q;
    case (state_q)
      S_IDLE: begin
        if (invalidate) begin
          valid_d = '0;
        end else if (rd_req && !hit) begin
          mem_addr_d = {addr[31:IDX_LSB], {IDX_LSB{1'b0}}};
          mem_req_d  = 1'b1;
          cnt_d      = '0;
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = S_REFILL;
        end else if (rd_req) begin
          hit_cnt_d = hit_cnt_q + 32'd1;
        end
      end
      S_REFILL: begin
        if (invalidate) inv_pend_d = 1'b1;
        if (mem_rvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            valid_d[ref_idx] = 1'b1;
            mem_req_d        = 1'b0;
            state_d          = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        // A fence.i seen during the refill (or now) wipes everything,
        // including the line just filled.
        if (inv_pend_q || invalidate) begin
          valid_d    = '0;
          inv_pend_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; reset aborts any refill in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      inv_pend_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      inv_pend_q <= inv_pend_d;
      valid_q    <= valid_d;
    end
  end

  // Data/tag arrays: written only by refill beats, qualified by valid bits
  always_ff @(posedge clk) begin
    if (state_q == S_REFILL && mem_rvalid) begin
      data_q[ref_idx][cnt_q] <= mem_rdata;
      if (last_beat) tag_q[ref_idx] <= ref_tag;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Randomized self-checking bench for inst_cache. The reference keeps a
// set of resident line numbers plus a backing-memory image; expected
// read data always comes straight from the memory image.
module tb_inst_cache;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] addr = '0;
  logic        invalidate = 1'b0;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  inst_cache dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .addr(addr),
    .invalidate(invalidate), .rd_data(rd_data), .miss(miss),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [31:0] bmem [0:1023];
  bit          resident [int unsigned];
  logic [31:0] m_hit = 0;
  logic [31:0] m_miss = 0;

  // Bring a line into the reference cache, evicting whatever shares its set
  task automatic model_fill(input int unsigned line);
    int unsigned victims[$];
    foreach (resident[k]) if ((k % 16) == (line % 16)) victims.push_back(k);
    foreach (victims[i]) resident.delete(victims[i]);
    resident[line] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One fetch of address a (a < 4KB). On a miss the line is served with
  // `gap` idle cycles before each beat; invalidate pulses on beat inv_beat,
  // reset is asserted on beat rst_beat (-1 disables either).
  task automatic fetch(input logic [31:0] a, input int gap,
                       input int inv_beat, input int rst_beat);
    logic [31:0] base;
    bit          inv_seen;
    base = {a[31:4], 4'b0};
    inv_seen = 1'b0;
    rd_req = 1'b1; addr = a; mem_rvalid = 1'b0; invalidate = 1'b0;
    #1;
    if (resident.exists(a >> 4)) begin
      checks++;
      if (miss !== 1'b0) begin failures++; $display("FAIL hit_miss a=%h got=%b exp=0", a, miss); end
      checks++;
      if (rd_data !== bmem[a[11:2]]) begin failures++; $display("FAIL hit_data a=%h got=%h exp=%h", a, rd_data, bmem[a[11:2]]); end
      tick();
      m_hit++;
      rd_req = 1'b0;
      return;
    end
    checks++;
    if (miss !== 1'b1) begin failures++; $display("FAIL miss_flag a=%h got=%b exp=1", a, miss); end
    tick();
    m_miss++;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        mem_rvalid = 1'b0;
        addr = $urandom; rd_req = 1'($urandom);
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== base || miss !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold beat=%0d got req=%b addr=%h miss=%b exp req=1 addr=%h miss=1", b, mem_req, mem_addr, miss, base);
        end
        tick();
      end
      addr = $urandom; rd_req = 1'($urandom);
      mem_rvalid = 1'b1;
      mem_rdata = bmem[base[11:2] + 10'(b)];
      invalidate = (b == inv_beat);
      if (invalidate) inv_seen = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== base || miss !== 1'b1) begin
        failures++;
        $display("FAIL refill_req beat=%0d got req=%b addr=%h miss=%b exp req=1 addr=%h miss=1", b, mem_req, mem_addr, miss, base);
      end
      if (b == rst_beat) begin
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || miss_cnt !== 32'd0 || hit_cnt !== 32'd0) begin
          failures++;
          $display("FAIL reset_abort got req=%b miss_cnt=%0d hit_cnt=%0d exp 0/0/0", mem_req, miss_cnt, hit_cnt);
        end
        resident.delete();
        m_hit = 0; m_miss = 0;
        tick();
        rst = 1'b1; mem_rvalid = 1'b0; invalidate = 1'b0; rd_req = 1'b0;
        return;
      end
      tick();
    end
    mem_rvalid = 1'b0; invalidate = 1'b0;
    addr = a; rd_req = 1'b1;
    #1;
    checks++;
    if (miss !== 1'b1 || mem_req !== 1'b0 || rd_data !== 32'd0) begin
      failures++;
      $display("FAIL done_cycle got miss=%b req=%b data=%h exp miss=1 req=0 data=0", miss, mem_req, rd_data);
    end
    tick();
    model_fill(a >> 4);
    if (inv_seen) resident.delete();
    rd_req = 1'b0;
  endtask

  task automatic inval();
    rd_req = 1'($urandom); addr = {20'd0, 12'($urandom)} & 32'hFFC;
    invalidate = 1'b1;
    tick();
    resident.delete();
    invalidate = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rd_req = 1'b0;
    #3;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'd0 || miss !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got req=%b addr=%h miss=%b exp 0/0/0", mem_req, mem_addr, miss);
    end
    checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_counters got hit=%0d miss=%0d exp 0/0", hit_cnt, miss_cnt);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    fetch(32'h0, 0, -1, -1);
    fetch(32'h0, 0, -1, -1);
    addr = 32'hC; rd_req = 1'b1; #1;
    checks++;
    if (rd_data !== 32'h44 || miss !== 1'b0) begin
      failures++; $display("FAIL basic_word3 got data=%h miss=%b exp data=00000044 miss=0", rd_data, miss);
    end
    fetch(32'hC, 0, -1, -1);
    checks++;
    if (hit_cnt !== 32'd2 || miss_cnt !== 32'd1) begin
      failures++; $display("FAIL basic_counters got hit=%0d miss=%0d exp 2/1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_conflict();
    fetch(32'h100, 0, -1, -1);
    fetch(32'h0, 0, -1, -1);
    checks++;
    if (miss_cnt !== 32'd3 || miss_cnt !== m_miss) begin
      failures++; $display("FAIL conflict_misses got %0d exp 3", miss_cnt);
    end
  endtask

  task automatic test_stall();
    fetch(32'h48, 3, -1, -1);
    fetch(32'h44, 0, -1, -1);
    fetch(32'h4C, 0, -1, -1);
  endtask

  task automatic test_invalidate();
    fetch(32'h54, 0, -1, -1);
    inval();
    fetch(32'h0, 0, -1, -1);
    fetch(32'h54, 0, -1, -1);
    fetch(32'h208, 1, 1, -1);
    fetch(32'h208, 0, -1, -1);
    fetch(32'h54, 0, -1, -1);
    checks++;
    if (hit_cnt !== m_hit || miss_cnt !== m_miss) begin
      failures++; $display("FAIL inval_counters got hit=%0d miss=%0d exp %0d/%0d", hit_cnt, miss_cnt, m_hit, m_miss);
    end
  endtask

  task automatic test_reset_mid_refill();
    fetch(32'h304, 0, -1, 1);
    fetch(32'h304, 1, -1, -1);
    fetch(32'h300, 0, -1, -1);
  endtask

  task automatic test_spurious_rvalid();
    rd_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    tick(); tick(); tick();
    mem_rvalid = 1'b0;
    fetch(32'h304, 0, -1, -1);
    fetch(32'h30C, 0, -1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int inv_b;
      if ($urandom_range(0, 9) == 0) inval();
      a = ($urandom_range(0, 31) << 4) | ($urandom_range(0, 3) << 2);
      inv_b = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      fetch(a, $urandom_range(0, 2), inv_b, -1);
    end
    checks++;
    if (hit_cnt !== m_hit || miss_cnt !== m_miss) begin
      failures++; $display("FAIL random_counters got hit=%0d miss=%0d exp %0d/%0d", hit_cnt, miss_cnt, m_hit, m_miss);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) bmem[i] = $urandom;
    bmem[0] = 32'h11; bmem[1] = 32'h22; bmem[2] = 32'h33; bmem[3] = 32'h44;
    @(negedge clk);
    test_reset();
    test_basic();
    test_conflict();
    test_stall();
    test_invalidate();
    test_reset_mid_refill();
    test_spurious_rvalid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
